alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Parametrised, handshaked ALU/shifter control sequencer for the multicycle datapath. Accepts one 4-bit ALU operation plus a shift amount from the main control unit, then drives ALU, shifter, ALUOut-mux and branch-compare controls over one or more cycles, including multi-cycle load-then-shift sequences. Signals completion with a one-cycle `done` pulse so the main control unit can advance its own state machine.

## Interface
- `AMT_W`, default 5: width of the shift amount input and shifter count output.
- `LUI_AMT`, default 16: fixed shift count used by LUI; must fit in `AMT_W` bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `op_valid`  in  1  operation request from the control unit.
- `op_ready`  out  1  high only in IDLE; accept when `op_valid && op_ready` at a rising edge.
- `op`  in  4  operation code, sampled on accept.
- `op_amt`  in  AMT_W  shift amount, sampled on accept; ignored by non-shift ops and LUI.
- `alu_ctl`  out  3  ALU function: 000 pass A, 001 add, 010 sub, 011 and, 111 compare.
- `sh_ctl`  out  3  shifter: 000 hold, 001 load, 010 shl, 011 shr logical, 100 shr arithmetic.
- `sh_n`  out  AMT_W  shift count presented with a shift command; 0 otherwise.
- `m_shifter`  out  1  shifter input select: 0 = B operand, 1 = immediate (LUI).
- `m_aluout`  out  2  ALUOut source: 00 hold, 01 ALU result, 10 shifter, 11 compare flag.
- `br_en`  out  1  branch compare active this cycle.
- `br_cond`  out  2  00 eq, 01 ne, 10 le, 11 gt.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse in the last cycle of each operation.

## Operation
- States: IDLE, EXEC, LOAD, SHIFT. All control outputs registered (decoded from state and captured op); `op_ready = (state == IDLE)`.
- Reset: state IDLE; `alu_ctl`, `sh_ctl`, `sh_n`, `m_shifter`, `m_aluout`, `br_en`, `br_cond`, `busy`, `done` all 0; `op_ready` 1 from the cycle after reset deasserts.
- IDLE: every control output 0 (m_aluout 00 = ALUOut holds).
- Single-cycle ops → EXEC, then IDLE:
  - 0 NOP: alu 000, m_aluout 01. 1 ADD: 001/01. 2 SUB: 010/01. 3 AND: 011/01.
  - 4 PASS_B: sh_ctl 001, m_aluout 10.
  - 10 SLT: alu 111, m_aluout 11.
  - 11 BEQ / 12 BNE / 13 BLE / 14 BGT: alu 111, m_aluout 11, br_en 1, br_cond 00/01/10/11.
- Shift ops → LOAD (sh_ctl 001, m_aluout 10), then SHIFT, then IDLE:
  - 5, 6 SHL; 7 SHR; 8, 9 SHRA; 15 LUI (m_shifter 1 in LOAD and SHIFT, shl by `LUI_AMT`).
  - SHIFT: sh_ctl = shift code, m_aluout 10, sh_n per Configuration.
- Amount 0 on a shift op (not LUI): SHIFT skipped; `done` in LOAD; result = loaded value.
- `op_valid` outside IDLE is ignored; `op` and `op_amt` are not re-sampled.
- Reset dominates everything: reset in any state returns to IDLE on that edge with all outputs cleared. No partial op survives.

## Timing
- Accept at edge k.
- Single-cycle op: controls and `done` valid in cycle k+1; `op_ready` high in k+2. Throughput: 1 op per 2 cycles.
- Shift op, non-iterative: LOAD in k+1; SHIFT with `done` in k+2; IDLE in k+3.
- Shift op, iterative: LOAD in k+1; SHIFT in k+2 .. k+1+amt; `done` in the last SHIFT cycle.
- `busy` = !`op_ready` outside reset. `done` never asserts for 2 consecutive cycles.

## Configuration
- Macro `ALUSEQ_ITER_SHIFT_EN`.
- Defined: for a shifter that moves one bit per command. SHIFT repeats with `sh_n` = 1, using an internal AMT_W-bit down-counter loaded with the amount and decremented each SHIFT cycle. Exits when the counter reaches 1. LUI takes `LUI_AMT` SHIFT cycles.
- Undefined: counter omitted. SHIFT lasts exactly one cycle with `sh_n` = amount (`LUI_AMT` for LUI).

## Test plan
- Reset held 3 cycles, then released → all outputs 0; `op_ready` 1; `busy` 0.
- op 1 (ADD) accepted at k → cycle k+1: alu_ctl 001, m_aluout 01, done 1. Cycle k+2: op_ready 1, all controls 0.
- op 13 (BLE) → one cycle with alu 111, m_aluout 11, br_en 1, br_cond 10, done 1. `op_valid` held high with op 1 during that cycle is not accepted until k+2.
- op 8 (SHRA), op_amt 3:
  - Non-iterative: LOAD (sh_ctl 001) then one SHIFT (sh_ctl 100, sh_n 3, done).
  - Iterative: three SHIFT cycles with sh_n 1; done only in the third.
- op 15 (LUI) → m_shifter 1 in LOAD and SHIFT; sh_ctl 010; sh_n 16 (non-iterative) or 16 SHIFT cycles (iterative). op 5 with op_amt 0 → done in LOAD, no SHIFT cycle.
- Reset asserted during the second SHIFT cycle of an iterative shift (op_amt 5) → next cycle IDLE, all outputs 0, no `done` pulse. A new ADD is accepted normally afterwards.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU/shifter control sequencer for the multicycle datapath.
// Takes one 4-bit operation (plus shift amount) from the main control unit
// and drives ALU, shifter, ALUOut-mux and branch-compare controls over one
// or more cycles, ending each operation with a one-cycle done pulse.
//
// Build option: define ALUSEQ_ITER_SHIFT_EN for a shifter that moves one bit
// per command (SHIFT repeats amount times with sh_n = 1). Without it, SHIFT
// is a single cycle presenting the whole amount on sh_n.
//
// Handshake: an operation is accepted at a rising edge where
// op_valid && op_ready; op_ready is high only in IDLE, op/op_amt are
// sampled only on accept, and op_valid in any other state is ignored.
//
// All control outputs are flops: the next-state values are decoded and
// registered so each output is aligned with the state it belongs to.
// The current state is exposed on dbg_state for checkers.

module alu_seq_ctrl #(
  parameter int AMT_W   = 5,
  parameter int LUI_AMT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op,
  input  logic [AMT_W-1:0] op_amt,
  output logic [2:0]       alu_ctl,
  output logic [2:0]       sh_ctl,
  output logic [AMT_W-1:0] sh_n,
  output logic             m_shifter,
  output logic [1:0]       m_aluout,
  output logic             br_en,
  output logic [1:0]       br_cond,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_LOAD  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  localparam logic [3:0]       OP_LUI = 4'd15;
  localparam logic [AMT_W-1:0] LUI_N  = AMT_W'(LUI_AMT);
  localparam logic [AMT_W-1:0] ONE_N  = AMT_W'(1);

  state_t           state, n_state;
  logic [3:0]       op_q, n_op;
  logic [AMT_W-1:0] amt_q, n_amt;

`ifdef ALUSEQ_ITER_SHIFT_EN
  logic [AMT_W-1:0] cnt_q, n_cnt;
`endif

  // next-cycle values of the registered outputs
  logic [2:0]       alu_d, sh_d;
  logic [AMT_W-1:0] sh_n_d;
  logic             m_sh_d, br_en_d, busy_d, done_d;
  logic [1:0]       mao_d, br_cond_d;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code inside {4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15});
  endfunction

  function automatic logic [2:0] shift_code(input logic [3:0] code);
    case (code)
      4'd7:       return 3'b011;
      4'd8, 4'd9: return 3'b100;
      default:    return 3'b010;
    endcase
  endfunction

  assign op_ready  = (state == S_IDLE);
  assign dbg_state = state;

  // state register plus captured op and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      amt_q     <= '0;
`ifdef ALUSEQ_ITER_SHIFT_EN
      cnt_q     <= '0;
`endif
      alu_ctl   <= '0;
      sh_ctl    <= '0;
      sh_n      <= '0;
      m_shifter <= 1'b0;
      m_aluout  <= '0;
      br_en     <= 1'b0;
      br_cond   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= n_state;
      op_q      <= n_op;
      amt_q     <= n_amt;
`ifdef ALUSEQ_ITER_SHIFT_EN
      cnt_q     <= n_cnt;
`endif
      alu_ctl   <= alu_d;
      sh_ctl    <= sh_d;
      sh_n      <= sh_n_d;
      m_shifter <= m_sh_d;
      m_aluout  <= mao_d;
      br_en     <= br_en_d;
      br_cond   <= br_cond_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // next-state: accept in IDLE, sequence EXEC or LOAD->SHIFT, back to IDLE
  always_comb begin
    n_state = state;
    n_op    = op_q;
    n_amt   = amt_q;
`ifdef ALUSEQ_ITER_SHIFT_EN
    n_cnt   = cnt_q;
`endif
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          n_op    = op;
          n_amt   = (op == OP_LUI) ? LUI_N : op_amt;
          n_state = is_shift_op(op) ? S_LOAD : S_EXEC;
        end
      end
      S_EXEC: n_state = S_IDLE;
      S_LOAD: begin
        // a zero-amount shift finishes with the loaded value
        if (op_q != OP_LUI && amt_q == '0) begin
          n_state = S_IDLE;
        end else begin
          n_state = S_SHIFT;
`ifdef ALUSEQ_ITER_SHIFT_EN
          n_cnt   = amt_q;
`endif
        end
      end
      S_SHIFT: begin
`ifdef ALUSEQ_ITER_SHIFT_EN
        if (cnt_q <= ONE_N) begin
          n_state = S_IDLE;
        end else begin
          n_cnt   = cnt_q - ONE_N;
        end
`else
        n_state = S_IDLE;
`endif
      end
      default: n_state = S_IDLE;
    endcase
  end

  // output decode from the next state and next captured op
  always_comb begin
    alu_d     = 3'b000;
    sh_d      = 3'b000;
    sh_n_d    = '0;
    m_sh_d    = 1'b0;
    mao_d     = 2'b00;
    br_en_d   = 1'b0;
    br_cond_d = 2'b00;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (n_state)
      S_EXEC: begin
        busy_d = 1'b1;
        done_d = 1'b1;
        case (n_op)
          4'd0: mao_d = 2'b01;
          4'd1: begin alu_d = 3'b001; mao_d = 2'b01; end
          4'd2: begin alu_d = 3'b010; mao_d = 2'b01; end
          4'd3: begin alu_d = 3'b011; mao_d = 2'b01; end
          4'd4: begin sh_d  = 3'b001; mao_d = 2'b10; end
          4'd10: begin alu_d = 3'b111; mao_d = 2'b11; end
          4'd11: begin alu_d = 3'b111; mao_d = 2'b11; br_en_d = 1'b1; br_cond_d = 2'b00; end
          4'd12: begin alu_d = 3'b111; mao_d = 2'b11; br_en_d = 1'b1; br_cond_d = 2'b01; end
          4'd13: begin alu_d = 3'b111; mao_d = 2'b11; br_en_d = 1'b1; br_cond_d = 2'b10; end
          4'd14: begin alu_d = 3'b111; mao_d = 2'b11; br_en_d = 1'b1; br_cond_d = 2'b11; end
          default: ;
        endcase
      end
      S_LOAD: begin
        busy_d = 1'b1;
        sh_d   = 3'b001;
        mao_d  = 2'b10;
        m_sh_d = (n_op == OP_LUI);
        done_d = (n_op != OP_LUI) && (n_amt == '0);
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        sh_d   = shift_code(n_op);
        mao_d  = 2'b10;
        m_sh_d = (n_op == OP_LUI);
`ifdef ALUSEQ_ITER_SHIFT_EN
        sh_n_d = ONE_N;
        done_d = (n_cnt == ONE_N);
`else
        sh_n_d = n_amt;
        done_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl. A reference model
// expands each operation into its expected per-cycle control vectors, which
// are queued and compared cycle by cycle against the DUT outputs.

module tb_alu_seq_ctrl;

  localparam int AMT_W   = 5;
  localparam int LUI_AMT = 16;
  localparam int VW      = 15 + AMT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [3:0]       op = '0;
  logic [AMT_W-1:0] op_amt = '0;
  logic [2:0]       alu_ctl, sh_ctl;
  logic [AMT_W-1:0] sh_n;
  logic             m_shifter, br_en, busy, done;
  logic [1:0]       m_aluout, br_cond, dbg_state;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  alu_seq_ctrl #(.AMT_W(AMT_W), .LUI_AMT(LUI_AMT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .op_amt(op_amt), .alu_ctl(alu_ctl), .sh_ctl(sh_ctl),
    .sh_n(sh_n), .m_shifter(m_shifter), .m_aluout(m_aluout),
    .br_en(br_en), .br_cond(br_cond), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] vec(
    input logic [2:0] alu, input logic [2:0] sh, input int n,
    input logic msh, input logic [1:0] mao, input logic be,
    input logic [1:0] bc, input logic bsy, input logic dn, input logic rdy);
    logic [AMT_W-1:0] nn;
    nn = AMT_W'(n);
    return {alu, sh, nn, msh, mao, be, bc, bsy, dn, rdy};
  endfunction

  function automatic logic [VW-1:0] actual_vec();
    return {alu_ctl, sh_ctl, sh_n, m_shifter, m_aluout, br_en, br_cond,
            busy, done, op_ready};
  endfunction

  function automatic logic [VW-1:0] idle_vec();
    return vec(3'b000, 3'b000, 0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endfunction

  // reference model: list of per-cycle control vectors for one operation
  task automatic build_expected(input int code, input int amt);
    bit lui;
    int n;
    logic [2:0] shc;
    case (code)
      0:  exp_q.push_back(vec(3'b000, 3'b000, 0, 0, 2'b01, 0, 2'b00, 1, 1, 0));
      1:  exp_q.push_back(vec(3'b001, 3'b000, 0, 0, 2'b01, 0, 2'b00, 1, 1, 0));
      2:  exp_q.push_back(vec(3'b010, 3'b000, 0, 0, 2'b01, 0, 2'b00, 1, 1, 0));
      3:  exp_q.push_back(vec(3'b011, 3'b000, 0, 0, 2'b01, 0, 2'b00, 1, 1, 0));
      4:  exp_q.push_back(vec(3'b000, 3'b001, 0, 0, 2'b10, 0, 2'b00, 1, 1, 0));
      10: exp_q.push_back(vec(3'b111, 3'b000, 0, 0, 2'b11, 0, 2'b00, 1, 1, 0));
      11: exp_q.push_back(vec(3'b111, 3'b000, 0, 0, 2'b11, 1, 2'b00, 1, 1, 0));
      12: exp_q.push_back(vec(3'b111, 3'b000, 0, 0, 2'b11, 1, 2'b01, 1, 1, 0));
      13: exp_q.push_back(vec(3'b111, 3'b000, 0, 0, 2'b11, 1, 2'b10, 1, 1, 0));
      14: exp_q.push_back(vec(3'b111, 3'b000, 0, 0, 2'b11, 1, 2'b11, 1, 1, 0));
      default: begin
        lui = (code == 15);
        n   = lui ? LUI_AMT : amt;
        if (code == 7) shc = 3'b011;
        else if (code == 8 || code == 9) shc = 3'b100;
        else shc = 3'b010;
        if (!lui && amt == 0) begin
          exp_q.push_back(vec(3'b000, 3'b001, 0, 0, 2'b10, 0, 2'b00, 1, 1, 0));
        end else begin
          exp_q.push_back(vec(3'b000, 3'b001, 0, lui, 2'b10, 0, 2'b00, 1, 0, 0));
`ifdef ALUSEQ_ITER_SHIFT_EN
          for (int i = 1; i <= n; i++)
            exp_q.push_back(vec(3'b000, shc, 1, lui, 2'b10, 0, 2'b00, 1, (i == n), 0));
`else
          exp_q.push_back(vec(3'b000, shc, n, lui, 2'b10, 0, 2'b00, 1, 1, 0));
`endif
        end
      end
    endcase
  endtask

  // driver: present op, wait (bounded) for op_ready, accept at next posedge
  task automatic issue(input int code, input int amt, input bit hold_valid,
                       output bit ok);
    int waited;
    op_valid = 1'b1;
    op       = 4'(code);
    op_amt   = AMT_W'(amt);
    waited   = 0;
    ok       = 1'b1;
    while (!op_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d op_ready=%b required 1", code, op_ready);
      op_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold_valid) begin
      op     = 4'd1;
      op_amt = AMT_W'($urandom_range(0, 31));
    end else begin
      op_valid = 1'b0;
    end
  endtask

  // scoreboard: compare every queued cycle, then the following idle cycle
  task automatic run_op(input string name, input int code, input int amt,
                        input bit hold_valid);
    logic [VW-1:0] e;
    bit ok;
    int cyc;
    exp_q.delete();
    build_expected(code, amt);
    issue(code, amt, hold_valid, ok);
    if (!ok) return;
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (actual_vec() !== e) begin
        errors++;
        $display("FAIL %s op=%0d amt=%0d cycle k+%0d got %h required %h",
                 name, code, amt, cyc, actual_vec(), e);
      end
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (actual_vec() !== idle_vec()) begin
      errors++;
      $display("FAIL %s_idle op=%0d got %h required %h",
               name, code, actual_vec(), idle_vec());
    end
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (actual_vec() !== idle_vec()) begin
      errors++;
      $display("FAIL reset_state got %h required %h", actual_vec(), idle_vec());
    end
  endtask

  task automatic test_single_cycle();
    run_op("add", 1, 0, 1'b0);
    run_op("sub", 2, 9, 1'b0);
    run_op("and", 3, 0, 1'b0);
    run_op("nop", 0, 0, 1'b0);
    run_op("pass_b", 4, 7, 1'b0);
    run_op("slt", 10, 0, 1'b0);
    run_op("ble_hold", 13, 0, 1'b1);
    run_op("beq", 11, 0, 1'b0);
    run_op("bgt", 14, 0, 1'b0);
  endtask

  task automatic test_shift();
    run_op("shra3", 8, 3, 1'b0);
    run_op("lui", 15, 5, 1'b0);
    run_op("shl_amt0", 5, 0, 1'b0);
    run_op("shr_max", 7, 31, 1'b1);
    run_op("shl1", 6, 1, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    logic [VW-1:0] e;
    bit ok;
    int pre;
    exp_q.delete();
    build_expected(5, 5);
`ifdef ALUSEQ_ITER_SHIFT_EN
    pre = 2;
`else
    pre = 1;
`endif
    issue(5, 5, 1'b0, ok);
    if (!ok) return;
    for (int i = 0; i < pre; i++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (actual_vec() !== e) begin
        errors++;
        $display("FAIL mid_reset_pre cycle %0d got %h required %h", i, actual_vec(), e);
      end
    end
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (actual_vec() !== idle_vec()) begin
      errors++;
      $display("FAIL mid_reset_idle got %h required %h", actual_vec(), idle_vec());
    end
    run_op("add_after_reset", 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shift();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
